// File: rtl/snoop_filter_pkg.sv
// Shared types and constants for the snoop filter tag-array controller.
package snoop_filter_pkg;

  localparam int SF_NSETS          = 64;
  localparam int SF_NWAYS          = 4;
  localparam int SF_BYTES_PER_LINE = 8;
  localparam int SF_MNT_STARVE_MAX = 8;
  localparam int SF_DATAW          = 64;
  localparam int SETW              = $clog2(SF_NSETS);

  typedef logic [SETW-1:0] set_t;

  localparam set_t LAST_SET = set_t'(SF_NSETS - 1);

  // Which requester a read response belongs to.
  typedef enum logic {
    SRC_REQ = 1'b0,
    SRC_MNT = 1'b1
  } src_e;

  // Controller phase: zeroing sweep, then normal arbitration.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One command as presented on the array pins.
  typedef struct packed {
    logic                wen;
    logic                mnt_ops;
    set_t                set_idx;
    logic [SF_DATAW-1:0] data;
  } sf_cmd_t;

  // Next set in the sweep order.
  function automatic set_t next_set(input set_t s);
    return s + set_t'(1);
  endfunction

endpackage

// File: rtl/snoop_filter_rsp_pipe.sv
// Two-stage valid/source shift register that lines a read's response tag up
// with the array's read data, one cycle after the command reaches the pins.
module snoop_filter_rsp_pipe
  import snoop_filter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  src_e in_src,
  output logic out_valid,
  output src_e out_src
);

  logic s1_valid, s2_valid;
  src_e s1_src, s2_src;

  // Shift the read tag two stages; reset drops anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_src   <= SRC_REQ;
      s2_src   <= SRC_REQ;
    end else begin
      s1_valid <= in_valid;
      s1_src   <= in_src;
      s2_valid <= s1_valid;
      s2_src   <= s1_src;
    end
  end

  assign out_valid = s2_valid;
  assign out_src   = s2_src;

endmodule

// File: rtl/snoop_filter_arb.sv
// Snoop filter tag-array controller: zeroes every set after reset, then
// arbitrates the single array port between the lookup pipeline and the
// maintenance engine, with a starvation bound that eventually forces
// maintenance through.
module snoop_filter_arb
  import snoop_filter_pkg::*;
#(
  parameter int MNT_STARVE_MAX = SF_MNT_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [SETW-1:0]     req_set,
  input  logic [SF_DATAW-1:0] req_wdata,
  input  logic                mnt_valid,
  output logic                mnt_ready,
  input  logic                mnt_wen,
  input  logic [SETW-1:0]     mnt_set,
  input  logic [SF_DATAW-1:0] mnt_wdata,
  output logic                rsp_valid,
  output logic                rsp_src,
  output logic [SF_DATAW-1:0] rsp_rdata,
  output logic                sf_cen,
  output logic                sf_wen,
  output logic                sf_mnt_ops,
  output logic [SETW-1:0]     sf_set_index,
  output logic [SF_DATAW-1:0] sf_data,
  input  logic [SF_DATAW-1:0] sf_rdata,
  output logic                init_done
);

  localparam int STW = $clog2(MNT_STARVE_MAX + 1);
  localparam logic [STW-1:0] STARVE_MAX = STW'(MNT_STARVE_MAX);

  state_e         state_q, state_d;
  set_t           init_cnt_q, init_cnt_d;
  logic [STW-1:0] starve_cnt_q, starve_cnt_d;
  sf_cmd_t        cmd_q, cmd_d;
  logic           cen_q, cen_d;

  logic running;
  logic starve_hit;
  logic req_go;
  logic mnt_go;
  logic rd_go;
  src_e rd_src;
  src_e rsp_src_e;

  assign running    = (state_q == ST_RUN);
  assign starve_hit = (starve_cnt_q == STARVE_MAX);
  assign req_ready  = running & ~(mnt_valid & starve_hit);
  assign mnt_ready  = running & (~req_valid | starve_hit);
  assign req_go     = req_valid & req_ready;
  assign mnt_go     = mnt_valid & mnt_ready;
  assign init_done  = running;

  // Register phase, sweep counter, starvation count and the array command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      starve_cnt_q <= '0;
      cen_q        <= 1'b1;
      cmd_q        <= '{wen: 1'b1, mnt_ops: 1'b1, set_idx: '0, data: '0};
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      cen_q        <= cen_d;
      cmd_q        <= cmd_d;
    end
  end

  // Choose the next array command: sweep writes in INIT, granted command in RUN.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    cen_d        = 1'b0;
    cmd_d        = cmd_q;
    starve_cnt_d = starve_cnt_q;

    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == LAST_SET) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = next_set(init_cnt_q);
          cen_d      = 1'b1;
          cmd_d      = '{wen: 1'b1, mnt_ops: 1'b1, set_idx: next_set(init_cnt_q), data: '0};
        end
      end
      ST_RUN: begin
        if (mnt_go) begin
          cen_d = 1'b1;
          cmd_d = '{wen: mnt_wen, mnt_ops: 1'b1, set_idx: mnt_set, data: mnt_wdata};
        end else if (req_go) begin
          cen_d = 1'b1;
          cmd_d = '{wen: req_wen, mnt_ops: 1'b0, set_idx: req_set, data: req_wdata};
        end
      end
    endcase

    if (!mnt_valid || mnt_go) begin
      starve_cnt_d = '0;
    end else if (!starve_hit) begin
      starve_cnt_d = starve_cnt_q + STW'(1);
    end
  end

  assign rd_go  = (mnt_go & ~mnt_wen) | (req_go & ~req_wen);
  assign rd_src = mnt_go ? SRC_MNT : SRC_REQ;

  snoop_filter_rsp_pipe u_rsp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_go),
    .in_src   (rd_src),
    .out_valid(rsp_valid),
    .out_src  (rsp_src_e)
  );

  assign rsp_src      = rsp_src_e;
  assign rsp_rdata    = sf_rdata;
  assign sf_cen       = cen_q;
  assign sf_wen       = cmd_q.wen;
  assign sf_mnt_ops   = cmd_q.mnt_ops;
  assign sf_set_index = cmd_q.set_idx;
  assign sf_data      = cmd_q.data;

endmodule

// File: tb/tb_snoop_filter_arb.sv
// Self-checking bench for snoop_filter_arb: behavioural array, a reference
// model of arbitration and read returns, directed and random steps.
module tb_snoop_filter_arb;
  import snoop_filter_pkg::*;

  localparam int NS   = SF_NSETS;
  localparam int SMAX = SF_MNT_STARVE_MAX;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_wen;
  logic [SETW-1:0] req_set;
  logic [63:0]     req_wdata;
  logic            mnt_valid, mnt_ready, mnt_wen;
  logic [SETW-1:0] mnt_set;
  logic [63:0]     mnt_wdata;
  logic            rsp_valid, rsp_src;
  logic [63:0]     rsp_rdata;
  logic            sf_cen, sf_wen, sf_mnt_ops;
  logic [SETW-1:0] sf_set_index;
  logic [63:0]     sf_data;
  logic [63:0]     sf_rdata;
  logic            init_done;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int              cyc;
  int              streak;
  logic [63:0]     mem_m [NS];
  logic            exp_cen, exp_wen, exp_mnt;
  logic [SETW-1:0] exp_set;
  logic [63:0]     exp_data;
  typedef struct {
    int          due;
    logic        src;
    logic [63:0] data;
  } rsp_t;
  rsp_t rq[$];

  logic obs_req_grant, obs_mnt_grant;

  always #5 clk = ~clk;

  snoop_filter_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wen     (req_wen),
    .req_set     (req_set),
    .req_wdata   (req_wdata),
    .mnt_valid   (mnt_valid),
    .mnt_ready   (mnt_ready),
    .mnt_wen     (mnt_wen),
    .mnt_set     (mnt_set),
    .mnt_wdata   (mnt_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_src     (rsp_src),
    .rsp_rdata   (rsp_rdata),
    .sf_cen      (sf_cen),
    .sf_wen      (sf_wen),
    .sf_mnt_ops  (sf_mnt_ops),
    .sf_set_index(sf_set_index),
    .sf_data     (sf_data),
    .sf_rdata    (sf_rdata),
    .init_done   (init_done)
  );

  // Behavioural single-port array with one-cycle read latency
  logic [63:0] sram [NS];
  always @(posedge clk) begin
    if (sf_cen) begin
      if (sf_wen) sram[sf_set_index] <= sf_data;
      else        sf_rdata <= sram[sf_set_index];
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic rw, input logic [SETW-1:0] rs,
                               input logic [63:0] rd, input logic mv, input logic mw,
                               input logic [SETW-1:0] ms, input logic [63:0] md);
    req_valid = rv; req_wen = rw; req_set = rs; req_wdata = rd;
    mnt_valid = mv; mnt_wen = mw; mnt_set = ms; mnt_wdata = md;
    #1;
  endtask

  task automatic modelReset();
    streak   = 0;
    cyc      = 0;
    exp_cen  = 1'b0;
    exp_wen  = 1'b1;
    exp_mnt  = 1'b1;
    exp_set  = SETW'(NS - 1);
    exp_data = '0;
    rq.delete();
    for (int i = 0; i < NS; i++) mem_m[i] = '0;
  endtask

  // Zeroing sweep starting in cycle 0 right after reset release
  task automatic doInit();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < NS; k++) begin
      checkOutput("init_cen", sf_cen, 1);
      checkOutput("init_wen", sf_wen, 1);
      checkOutput("init_mnt_ops", sf_mnt_ops, 1);
      checkOutput("init_set", sf_set_index, k);
      checkOutput("init_data", sf_data, 0);
      checkOutput("init_req_ready", req_ready, 0);
      checkOutput("init_mnt_ready", mnt_ready, 0);
      checkOutput("init_done_low", init_done, 0);
      checkOutput("init_rsp_valid", rsp_valid, 0);
      @(posedge clk); @(negedge clk); #1;
    end
    checkOutput("init_done_high", init_done, 1);
    modelReset();
  endtask

  // One RUN cycle: drive, compare against the model, then advance the model past the edge
  task automatic stepRun(input logic rv, input logic rw, input logic [SETW-1:0] rs,
                         input logic [63:0] rd, input logic mv, input logic mw,
                         input logic [SETW-1:0] ms, input logic [63:0] md);
    bit hit, mwin, rwin;
    applyStimulus(rv, rw, rs, rd, mv, mw, ms, md);
    hit  = (streak >= SMAX);
    mwin = mv && (!rv || hit);
    rwin = rv && !(mv && hit);
    checkOutput("req_ready", req_ready, !(mv && hit));
    checkOutput("mnt_ready", mnt_ready, (!rv || hit));
    checkOutput("init_done", init_done, 1);
    checkOutput("sf_cen", sf_cen, exp_cen);
    if (exp_cen) begin
      checkOutput("sf_wen", sf_wen, exp_wen);
      checkOutput("sf_mnt_ops", sf_mnt_ops, exp_mnt);
      checkOutput("sf_set_index", sf_set_index, exp_set);
      checkOutput("sf_data", sf_data, exp_data);
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      checkOutput("rsp_valid", rsp_valid, 1);
      checkOutput("rsp_src", rsp_src, rq[0].src);
      checkOutput("rsp_rdata", rsp_rdata, rq[0].data);
      void'(rq.pop_front());
    end else begin
      checkOutput("rsp_valid_idle", rsp_valid, 0);
    end
    obs_req_grant = rv && req_ready;
    obs_mnt_grant = mv && mnt_ready;
    if (mwin || rwin) begin
      exp_cen  = 1'b1;
      exp_wen  = mwin ? mw : rw;
      exp_mnt  = mwin;
      exp_set  = mwin ? ms : rs;
      exp_data = mwin ? md : rd;
      if (exp_wen) mem_m[exp_set] = exp_data;
      else rq.push_back('{cyc + 2, mwin, mem_m[exp_set]});
    end else begin
      exp_cen = 1'b0;
    end
    if (mv && !mwin) streak = (streak < SMAX) ? streak + 1 : SMAX;
    else streak = 0;
    @(posedge clk); @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) stepRun(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [SF_NSETS-1:0] dummy;
    logic [63:0] d;
    logic [26:0] exp_pat, obs_pat;
    dummy = '0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] checking reset values");
    checkOutput("rst_sf_cen", sf_cen, 1);
    checkOutput("rst_sf_wen", sf_wen, 1);
    checkOutput("rst_sf_mnt_ops", sf_mnt_ops, 1);
    checkOutput("rst_sf_set", sf_set_index, 0);
    checkOutput("rst_sf_data", sf_data, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_src", rsp_src, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_mnt_ready", mnt_ready, 0);
    rst = 1'b0;
    $display("[TB] init sweep");
    doInit();

    $display("[TB] mnt write then req read of set 5");
    d = {$urandom, $urandom};
    stepRun(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, SETW'(5), d);
    stepRun(1'b1, 1'b0, SETW'(5), '0, 1'b0, 1'b0, '0, '0);
    idle(3);

    $display("[TB] mnt write set 63 with req idle");
    stepRun(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, SETW'(63), 64'hDEAD_BEEF);
    checkOutput("mnt_same_cycle_grant", obs_mnt_grant, 1);
    idle(2);

    $display("[TB] starvation bound with both requesters held");
    for (int i = 0; i < 27; i++) exp_pat[i] = ((i % (SMAX + 1)) == SMAX);
    for (int i = 0; i < 27; i++) begin
      stepRun(1'b1, 1'b0, SETW'($urandom_range(0, NS - 1)), '0,
              1'b1, 1'b0, SETW'($urandom_range(0, NS - 1)), '0);
      obs_pat[i] = obs_mnt_grant;
      if (obs_req_grant == obs_mnt_grant) begin
        checkOutput("one_grant_per_cycle", {obs_req_grant, obs_mnt_grant}, 2'b01);
      end
    end
    checkOutput("starve_pattern", obs_pat, exp_pat);
    idle(3);

    $display("[TB] back-to-back reads of sets 1,2,3");
    for (int s = 1; s <= 3; s++)
      stepRun(1'b1, 1'b1, SETW'(s), {$urandom, $urandom}, 1'b0, 1'b0, '0, '0);
    for (int s = 1; s <= 3; s++)
      stepRun(1'b1, 1'b0, SETW'(s), '0, 1'b0, 1'b0, '0, '0);
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      stepRun(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              SETW'($urandom_range(0, NS - 1)), {$urandom, $urandom},
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
              SETW'($urandom_range(0, NS - 1)), {$urandom, $urandom});
    end
    idle(3);

    $display("[TB] reset with a read in flight");
    stepRun(1'b1, 1'b0, SETW'(7), '0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    checkOutput("midrst_init_done", init_done, 0);
    checkOutput("midrst_rsp_valid", rsp_valid, 0);
    checkOutput("midrst_sf_set", sf_set_index, 0);
    checkOutput("midrst_sf_mnt_ops", sf_mnt_ops, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk); #1;
      checkOutput("midrst_rsp_hold", rsp_valid, 0);
    end
    rst = 1'b0;
    doInit();
    for (int i = 0; i < 20; i++) begin
      stepRun(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              SETW'($urandom_range(0, NS - 1)), {$urandom, $urandom},
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              SETW'($urandom_range(0, NS - 1)), {$urandom, $urandom});
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
